// File: rtl/ahb_arbiter.sv
// ahb_arbiter: round-robin arbiter that lets N_MASTERS AHB-Lite masters share
// one slave-side bus. Address-phase signals are muxed from the address owner
// and write data from the data-phase owner. Ownership moves only at
// arbitration points: bus ready, no lock, and the owner is IDLE or issuing a
// NONSEQ SINGLE. A master that does not own the bus sees m_hready low and
// holds its own request; nothing is buffered here.
module ahb_arbiter #(
    parameter int N_MASTERS      = 2,
    parameter int AHB_ADDR_WIDTH = 32,
    parameter int AHB_DATA_WIDTH = 32
) (
    input  logic                                hclk,
    input  logic                                hreset,
    input  logic [N_MASTERS*AHB_ADDR_WIDTH-1:0] m_haddr,
    input  logic [N_MASTERS*2-1:0]              m_htrans,
    input  logic [N_MASTERS-1:0]                m_hwrite,
    input  logic [N_MASTERS*3-1:0]              m_hsize,
    input  logic [N_MASTERS*3-1:0]              m_hburst,
    input  logic [N_MASTERS*4-1:0]              m_hprot,
    input  logic [N_MASTERS-1:0]                m_hmastlock,
    input  logic [N_MASTERS*AHB_DATA_WIDTH-1:0] m_hwdata,
    output logic [N_MASTERS-1:0]                m_hready,
    output logic [N_MASTERS-1:0]                m_hresp,
    output logic [AHB_DATA_WIDTH-1:0]           m_hrdata,
    output logic [AHB_ADDR_WIDTH-1:0]           s_haddr,
    output logic                                s_hwrite,
    output logic [2:0]                          s_hsize,
    output logic [2:0]                          s_hburst,
    output logic [3:0]                          s_hprot,
    output logic [1:0]                          s_htrans,
    output logic                                s_hmastlock,
    output logic [AHB_DATA_WIDTH-1:0]           s_hwdata,
    output logic                                s_hsel,
    output logic                                s_hready,
    input  logic                                s_hreadyout,
    input  logic                                s_hresp,
    input  logic [AHB_DATA_WIDTH-1:0]           s_hrdata
);

    localparam int IW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    typedef logic [IW-1:0] idx_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    // Registered arbitration state
    idx_t addr_owner;
    idx_t data_owner;
    logic data_valid;
    idx_t rr_ptr;

    idx_t addr_owner_nxt;
    idx_t rr_ptr_nxt;

    // Owner-side views of the request and a request vector
    logic [N_MASTERS-1:0] req;
    logic                 arb_point;
    logic                 other_found;
    idx_t                 other_idx;
    logic                 own_req;

    // Next round-robin position after a given winner, wrapping at N_MASTERS
    function automatic idx_t rr_next(input idx_t winner);
        idx_t r;
        if (winner == idx_t'(N_MASTERS - 1)) begin
            r = '0;
        end else begin
            r = winner + 1'b1;
        end
        return r;
    endfunction

    // Decode which masters currently have a transfer pending
    always_comb begin
        req = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            req[i] = (m_htrans[i*2 +: 2] != HTRANS_IDLE);
        end
    end

    // Forward the address-phase signals of the current address owner
    always_comb begin
        s_haddr     = m_haddr[0 +: AHB_ADDR_WIDTH];
        s_htrans    = m_htrans[1:0];
        s_hwrite    = m_hwrite[0];
        s_hsize     = m_hsize[2:0];
        s_hburst    = m_hburst[2:0];
        s_hprot     = m_hprot[3:0];
        s_hmastlock = m_hmastlock[0];
        for (int i = 0; i < N_MASTERS; i++) begin
            if (idx_t'(i) == addr_owner) begin
                s_haddr     = m_haddr[i*AHB_ADDR_WIDTH +: AHB_ADDR_WIDTH];
                s_htrans    = m_htrans[i*2 +: 2];
                s_hwrite    = m_hwrite[i];
                s_hsize     = m_hsize[i*3 +: 3];
                s_hburst    = m_hburst[i*3 +: 3];
                s_hprot     = m_hprot[i*4 +: 4];
                s_hmastlock = m_hmastlock[i];
            end
        end
    end

    // Forward write data from the data-phase owner; read data is broadcast
    always_comb begin
        s_hwdata = m_hwdata[0 +: AHB_DATA_WIDTH];
        for (int i = 0; i < N_MASTERS; i++) begin
            if (idx_t'(i) == data_owner) begin
                s_hwdata = m_hwdata[i*AHB_DATA_WIDTH +: AHB_DATA_WIDTH];
            end
        end
    end

    assign m_hrdata = s_hrdata;
    assign s_hsel   = (s_htrans != HTRANS_IDLE);
    assign s_hready = s_hreadyout;

    // Route ready to both owners and the response only to the data owner
    always_comb begin
        m_hready = '0;
        m_hresp  = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if ((idx_t'(i) == addr_owner) ||
                (data_valid && (idx_t'(i) == data_owner))) begin
                m_hready[i] = s_hreadyout;
            end
            if (data_valid && (idx_t'(i) == data_owner)) begin
                m_hresp[i] = s_hresp;
            end
        end
    end

    // Ownership may only move when the owner is between transfers or on a
    // single-beat transfer, the bus is ready and no lock is held. Bursts of
    // undefined length (INCR) keep the bus until the owner goes IDLE.
    assign own_req   = (s_htrans != HTRANS_IDLE);
    assign arb_point = s_hreadyout && !s_hmastlock &&
                       ((s_htrans == HTRANS_IDLE) ||
                        ((s_htrans == HTRANS_NONSEQ) && (s_hburst == HBURST_SINGLE)));

    // Round-robin scan from rr_ptr for the first requester other than the owner
    always_comb begin
        int cand;
        cand        = 0;
        other_found = 1'b0;
        other_idx   = addr_owner;
        for (int k = 0; k < N_MASTERS; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= N_MASTERS) begin
                cand = cand - N_MASTERS;
            end
            if (!other_found && req[cand] && (idx_t'(cand) != addr_owner)) begin
                other_found = 1'b1;
                other_idx   = idx_t'(cand);
            end
        end
    end

    // Grant decision: another requester wins, else the owner keeps the bus
    always_comb begin
        addr_owner_nxt = addr_owner;
        rr_ptr_nxt     = rr_ptr;
        if (arb_point) begin
            if (other_found) begin
                addr_owner_nxt = other_idx;
                rr_ptr_nxt     = rr_next(other_idx);
            end else if (own_req) begin
                rr_ptr_nxt     = rr_next(addr_owner);
            end
        end
    end

    // Arbitration and data-phase state; everything freezes during wait states
    always_ff @(posedge hclk) begin
        if (hreset) begin
            addr_owner <= '0;
            data_owner <= '0;
            data_valid <= 1'b0;
            rr_ptr     <= idx_t'(1 % N_MASTERS);
        end else if (s_hreadyout) begin
            addr_owner <= addr_owner_nxt;
            rr_ptr     <= rr_ptr_nxt;
            data_owner <= addr_owner;
            data_valid <= s_htrans[1];
        end
    end

endmodule
